cmac_seq: RTL and testbench

CMAC_SEQ -- requirements
Module: cmac_seq

---
 rtl/cmac_seq.sv | 169 ++++++++++++++++
 tb/tb_cmac_seq.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_seq.sv
// Convolution MAC sequencer: streams a window of FP16 data/weight pairs from
// the operand buffers into a MAC, then captures and presents the accumulated result.
module cmac_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_len,
  input  logic [11:0] cmd_daddr,
  input  logic [11:0] cmd_waddr,
  output logic        buf_rd_en,
  output logic [11:0] buf_daddr,
  output logic [11:0] buf_waddr,
  input  logic [15:0] buf_data,
  input  logic [15:0] buf_weight,
  output logic        mac_conv_valid,
  input  logic        mac_conv_ready,
  input  logic        mac_data_ready,
  output logic        mac_data_valid,
  output logic [15:0] mac_data,
  output logic [15:0] mac_weight,
  input  logic [15:0] mac_result,
  output logic        res_valid,
  output logic [15:0] res_data,
  input  logic        res_ready,
  output logic        busy,
  output logic        err,
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; a valid, once raised, holds its payload stable until that edge.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_q;
  logic [11:0] daddr_q;
  logic [11:0] waddr_q;
  logic [7:0]  issued_q;
  logic [7:0]  xfer_cnt_q;
  logic        rd_pend_q;
  logic        op_valid_q;
  logic [15:0] op_data_q;
  logic [15:0] op_weight_q;
  logic        skid_valid_q;
  logic [15:0] skid_data_q;
  logic [15:0] skid_weight_q;
  logic [15:0] res_q;
  logic        err_q;

  logic        accept;
  logic        xfer;
  logic        last_xfer;
  logic        early;
  logic [1:0]  occ;
  logic        rd_room;

  assign accept    = (state_q == S_IDLE) && cmd_valid;
  assign xfer      = op_valid_q && mac_data_ready;
  assign last_xfer = xfer && ((xfer_cnt_q + 8'd1) == len_q);
  assign early     = (state_q == S_FEED) && mac_conv_ready;

  // Pairs held or inbound; a new read needs a free slot even if the MAC
  // stalls next cycle, which the skid register provides at full rate.
  assign occ     = 2'(op_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q);
  assign rd_room = occ <= (2'd1 + 2'(xfer));

  assign buf_rd_en = (state_q == S_FEED) && (issued_q < len_q) && rd_room && !mac_conv_ready;
  assign buf_daddr = daddr_q + {4'd0, issued_q};
  assign buf_waddr = waddr_q + {4'd0, issued_q};

  assign cmd_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign mac_conv_valid = (state_q == S_FEED) || (state_q == S_WAIT);
  assign mac_data_valid = op_valid_q;
  assign mac_data       = op_data_q;
  assign mac_weight     = op_weight_q;
  assign res_valid      = (state_q == S_OUT);
  assign res_data       = res_q;
  assign err            = err_q;
  assign state_dbg      = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (cmd_len != 8'd0) ? S_FEED : S_OUT;
      S_FEED: begin
        if (mac_conv_ready) state_d = S_OUT;
        else if (last_xfer) state_d = S_WAIT;
      end
      S_WAIT: if (mac_conv_ready) state_d = S_OUT;
      S_OUT:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      daddr_q       <= '0;
      waddr_q       <= '0;
      issued_q      <= '0;
      xfer_cnt_q    <= '0;
      rd_pend_q     <= 1'b0;
      op_valid_q    <= 1'b0;
      op_data_q     <= '0;
      op_weight_q   <= '0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_weight_q <= '0;
      res_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= buf_rd_en;

      if (accept) begin
        len_q      <= cmd_len;
        daddr_q    <= cmd_daddr;
        waddr_q    <= cmd_waddr;
        issued_q   <= '0;
        xfer_cnt_q <= '0;
        err_q      <= 1'b0;
        if (cmd_len == 8'd0) res_q <= '0;
      end

      if (buf_rd_en) issued_q <= issued_q + 8'd1;
      if (xfer) xfer_cnt_q <= xfer_cnt_q + 8'd1;

      if (mac_conv_ready && ((state_q == S_FEED) || (state_q == S_WAIT))) res_q <= mac_result;
      if (early) err_q <= 1'b1;

      // Operand path: the skid entry is always older than any pair arriving now.
      if (early) begin
        op_valid_q   <= 1'b0;
        skid_valid_q <= 1'b0;
      end else if (!op_valid_q || xfer) begin
        if (skid_valid_q) begin
          op_valid_q   <= 1'b1;
          op_data_q    <= skid_data_q;
          op_weight_q  <= skid_weight_q;
          skid_valid_q <= rd_pend_q;
          if (rd_pend_q) begin
            skid_data_q   <= buf_data;
            skid_weight_q <= buf_weight;
          end
        end else if (rd_pend_q) begin
          op_valid_q  <= 1'b1;
          op_data_q   <= buf_data;
          op_weight_q <= buf_weight;
        end else begin
          op_valid_q <= 1'b0;
        end
      end else if (rd_pend_q) begin
        skid_valid_q  <= 1'b1;
        skid_data_q   <= buf_data;
        skid_weight_q <= buf_weight;
      end
    end
  end

endmodule

// File: tb/tb_cmac_seq.sv
// Bench for cmac_seq: buffer and MAC models, a window-level reference model
// and per-scenario checks of pairs, addresses, results and handshakes.
module tb_cmac_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_len;
  logic [11:0] cmd_daddr;
  logic [11:0] cmd_waddr;
  logic        buf_rd_en;
  logic [11:0] buf_daddr;
  logic [11:0] buf_waddr;
  logic [15:0] buf_data;
  logic [15:0] buf_weight;
  logic        mac_conv_valid;
  logic        mac_conv_ready;
  logic        mac_data_ready;
  logic        mac_data_valid;
  logic [15:0] mac_data;
  logic [15:0] mac_weight;
  logic [15:0] mac_result;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready;
  logic        busy;
  logic        err;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  cmac_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_daddr(cmd_daddr), .cmd_waddr(cmd_waddr),
    .buf_rd_en(buf_rd_en), .buf_daddr(buf_daddr), .buf_waddr(buf_waddr),
    .buf_data(buf_data), .buf_weight(buf_weight),
    .mac_conv_valid(mac_conv_valid), .mac_conv_ready(mac_conv_ready),
    .mac_data_ready(mac_data_ready), .mac_data_valid(mac_data_valid),
    .mac_data(mac_data), .mac_weight(mac_weight), .mac_result(mac_result),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] dmem [4096];
  logic [15:0] wmem [4096];

  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];
  logic [23:0] exp_addr_q[$];
  logic [23:0] addr_q[$];
  int          xfer_cyc[$];
  int          cyc = 0;
  int          stab_viol = 0;
  int          rd_outside = 0;
  int          cv_cycles = 0;
  logic        stall_pend = 1'b0;
  logic [15:0] hold_d, hold_w;

  int          ready_mode = 0;
  int          tog = 0;
  logic [15:0] got_res;
  logic        got_err, acc_err;
  logic        hold_ok, idle_ok, cv_ok, done_ok, outs_ok, post_rd_ok;
  logic        pairs_bad, addr_bad;
  int          res_lat;
  int          n_rd_at;

  // Buffer model: registered read, data valid one cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    if (buf_rd_en) begin
      buf_data   <= dmem[buf_daddr];
      buf_weight <= wmem[buf_waddr];
    end else begin
      buf_data   <= 16'($urandom);
      buf_weight <= 16'($urandom);
    end
  end

  // Monitor: records MAC transfers and reads, and operand stability during stalls.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (stall_pend && !(mac_data_valid && mac_data === hold_d && mac_weight === hold_w))
        stab_viol++;
      if (mac_data_valid && mac_data_ready) begin
        act_q.push_back({mac_data, mac_weight});
        xfer_cyc.push_back(cyc);
      end
      if (buf_rd_en) begin
        addr_q.push_back({buf_daddr, buf_waddr});
        if (!mac_conv_valid || mac_conv_ready) rd_outside++;
      end
      if (mac_conv_valid) cv_cycles++;
    end
    stall_pend = !rst && mac_data_valid && !mac_data_ready && !mac_conv_ready;
    hold_d = mac_data;
    hold_w = mac_weight;
  end

  task automatic drive_ready();
    case (ready_mode)
      0: mac_data_ready = 1'b1;
      1: mac_data_ready = (tog % 3 == 0);
      default: mac_data_ready = 1'($urandom_range(0, 1));
    endcase
    tog++;
  endtask

  task automatic send_cmd(input logic [7:0] len, input logic [11:0] da, input logic [11:0] wa);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) done_ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_daddr = da;
    cmd_waddr = wa;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_len   = 8'($urandom);
    cmd_daddr = 12'($urandom);
    cmd_waddr = 12'($urandom);
  endtask

  // Runs one window; early_n >= 0 makes the MAC finish after that many transfers.
  task automatic run_cmd(input logic [7:0] len, input logic [11:0] da, input logic [11:0] wa,
                         input int early_n, input logic [15:0] result);
    int guard = 0;
    logic fired = 1'b0;
    int tgt;
    int a, b;
    act_q.delete(); addr_q.delete(); exp_q.delete(); exp_addr_q.delete(); xfer_cyc.delete();
    stab_viol = 0; rd_outside = 0; cv_cycles = 0; tog = 0; n_rd_at = 0;
    done_ok = 1'b1; cv_ok = 1'b1; hold_ok = 1'b1; res_lat = 0;
    for (int i = 0; i < int'(len); i++) begin
      a = (int'(da) + i) % 4096;
      b = (int'(wa) + i) % 4096;
      exp_q.push_back({dmem[a], wmem[b]});
      exp_addr_q.push_back({12'(a), 12'(b)});
    end
    if (early_n >= 0) while (exp_q.size() > early_n) void'(exp_q.pop_back());
    mac_conv_ready = 1'b0;
    res_ready = 1'b0;
    drive_ready();
    send_cmd(len, da, wa);
    acc_err = err;
    if (len == 8'd0) begin
      res_lat = 1;
      while (!res_valid && res_lat < 6) begin
        @(negedge clk);
        res_lat++;
      end
    end else begin
      tgt = (early_n >= 0) ? early_n : int'(len);
      while (!fired && guard < 4000) begin
        if (!mac_conv_valid) cv_ok = 1'b0;
        if (act_q.size() >= tgt) begin
          mac_conv_ready = 1'b1;
          mac_result = result;
          mac_data_ready = 1'b0;
          n_rd_at = addr_q.size();
          fired = 1'b1;
        end else begin
          drive_ready();
        end
        @(negedge clk);
        guard++;
      end
      mac_conv_ready = 1'b0;
      mac_result = 16'($urandom);
      if (!fired) done_ok = 1'b0;
    end
    got_res = res_data;
    got_err = err;
    outs_ok = res_valid && busy && !mac_conv_valid && !mac_data_valid && !cmd_ready;
    repeat ($urandom_range(1, 4)) begin
      if (!res_valid || res_data !== got_res || cmd_ready) hold_ok = 1'b0;
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    idle_ok = cmd_ready && !res_valid && !busy;
    post_rd_ok = (addr_q.size() == n_rd_at);
    pairs_bad = (act_q.size() != exp_q.size());
    if (!pairs_bad) foreach (exp_q[i]) if (act_q[i] !== exp_q[i]) pairs_bad = 1'b1;
    addr_bad = (early_n < 0) ? (addr_q.size() != exp_addr_q.size()) : (addr_q.size() > exp_addr_q.size());
    if (!addr_bad) foreach (addr_q[i]) if (addr_q[i] !== exp_addr_q[i]) addr_bad = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
    end
    checks++;
    if ({buf_rd_en, buf_daddr, buf_waddr, mac_conv_valid, mac_data_valid, mac_data, mac_weight,
         res_valid, res_data, busy, err, state_dbg} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%b%h%h%b%b%h%h%b%h%b%b%h exp=all zero", buf_rd_en, buf_daddr,
        buf_waddr, mac_conv_valid, mac_data_valid, mac_data, mac_weight, res_valid, res_data, busy, err, state_dbg);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nine();
    logic [15:0] tab [9];
    tab = '{16'h3c00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800, 16'h4880};
    for (int i = 0; i < 9; i++) begin
      dmem[i] = tab[i];
      wmem[i] = tab[i];
    end
    ready_mode = 0;
    run_cmd(8'd9, 12'd0, 12'd0, -1, 16'h5C74);
    checks++;
    if (pairs_bad || !done_ok) begin
      errors++; $display("FAIL nine_pairs got=%0d pairs exp=9 done=%b", act_q.size(), done_ok);
    end
    checks++;
    if (addr_bad) begin
      errors++; $display("FAIL nine_addrs got=%0d reads exp=9 at 0..8", addr_q.size());
    end
    checks++;
    if (xfer_cyc.size() != 9 || xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[0] != 8) begin
      errors++; $display("FAIL nine_consecutive got=%0d transfers exp=9 in 9 cycles", xfer_cyc.size());
    end
    checks++;
    if (got_res !== 16'h5C74 || got_err !== 1'b0) begin
      errors++; $display("FAIL nine_result got=%h err=%b exp=5c74 err=0", got_res, got_err);
    end
    checks++;
    if (!hold_ok || !idle_ok || !cv_ok || !outs_ok) begin
      errors++; $display("FAIL nine_handshake got=hold%b idle%b cv%b out%b exp=1111", hold_ok, idle_ok, cv_ok, outs_ok);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] len = 8'($urandom_range(5, 12));
    logic [15:0] r = 16'($urandom);
    ready_mode = 1;
    run_cmd(len, 12'($urandom), 12'($urandom), -1, r);
    checks++;
    if (pairs_bad || !done_ok) begin
      errors++; $display("FAIL bp_pairs got=%0d pairs exp=%0d", act_q.size(), len);
    end
    checks++;
    if (stab_viol != 0 || rd_outside != 0) begin
      errors++; $display("FAIL bp_stable got=%0d unstable %0d stray reads exp=0 0", stab_viol, rd_outside);
    end
    checks++;
    if (got_res !== r || addr_bad) begin
      errors++; $display("FAIL bp_result got=%h addr_bad=%b exp=%h addr_bad=0", got_res, addr_bad, r);
    end
  endtask

  task automatic test_len_zero();
    ready_mode = 0;
    run_cmd(8'd0, 12'($urandom), 12'($urandom), -1, 16'h0);
    checks++;
    if (res_lat > 2 || got_res !== 16'h0000) begin
      errors++; $display("FAIL len0_result got=%h after %0d cycles exp=0000 within 2", got_res, res_lat);
    end
    checks++;
    if (addr_q.size() != 0 || cv_cycles != 0 || act_q.size() != 0) begin
      errors++; $display("FAIL len0_quiet got=%0d reads %0d conv cycles exp=0 0", addr_q.size(), cv_cycles);
    end
    checks++;
    if (!idle_ok || !hold_ok) begin
      errors++; $display("FAIL len0_handshake got=idle%b hold%b exp=11", idle_ok, hold_ok);
    end
  endtask

  task automatic test_wrap();
    logic [23:0] want [4];
    logic bad = 1'b0;
    want = '{{12'd4094, 12'd10}, {12'd4095, 12'd11}, {12'd0, 12'd12}, {12'd1, 12'd13}};
    ready_mode = 2;
    run_cmd(8'd4, 12'd4094, 12'd10, -1, 16'h1234);
    if (addr_q.size() != 4) bad = 1'b1;
    else for (int i = 0; i < 4; i++) if (addr_q[i] !== want[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++; $display("FAIL wrap_addrs got=%0d reads first=%h exp=4 reads ffe00a..00100d", addr_q.size(),
        (addr_q.size() > 0) ? addr_q[0] : 24'hx);
    end
    checks++;
    if (pairs_bad || got_res !== 16'h1234) begin
      errors++; $display("FAIL wrap_pairs got=%0d pairs res=%h exp=4 pairs res=1234", act_q.size(), got_res);
    end
  endtask

  task automatic test_early();
    logic [15:0] r = 16'($urandom);
    ready_mode = 0;
    run_cmd(8'd9, 12'($urandom), 12'($urandom), 3, r);
    checks++;
    if (got_err !== 1'b1 || got_res !== r) begin
      errors++; $display("FAIL early_err got=err%b res=%h exp=err1 res=%h", got_err, got_res, r);
    end
    checks++;
    if (pairs_bad || addr_bad || !post_rd_ok || n_rd_at < 3) begin
      errors++; $display("FAIL early_abandon got=%0d pairs %0d reads exp=3 pairs no later reads", act_q.size(), addr_q.size());
    end
    checks++;
    if (!outs_ok || !idle_ok || rd_outside != 0) begin
      errors++; $display("FAIL early_outputs got=out%b idle%b stray%0d exp=1 1 0", outs_ok, idle_ok, rd_outside);
    end
    run_cmd(8'd3, 12'($urandom), 12'($urandom), -1, 16'h3c00);
    checks++;
    if (acc_err !== 1'b0 || got_err !== 1'b0 || pairs_bad) begin
      errors++; $display("FAIL early_clear got=err%b/%b pairs_bad%b exp=0 0 0", acc_err, got_err, pairs_bad);
    end
  endtask

  task automatic test_reset_mid();
    mac_data_ready = 1'b1;
    send_cmd(8'd9, 12'h100, 12'h200);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || {buf_rd_en, mac_conv_valid, mac_data_valid, mac_data, mac_weight,
        res_valid, res_data, busy, err, state_dbg} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got=ready%b rd%b cv%b dv%b busy%b exp=ready1 rest 0",
        cmd_ready, buf_rd_en, mac_conv_valid, mac_data_valid, busy);
    end
    ready_mode = 0;
    run_cmd(8'd2, 12'($urandom), 12'($urandom), -1, 16'h4200);
    checks++;
    if (pairs_bad || addr_bad || got_res !== 16'h4200 || got_err !== 1'b0 || !idle_ok) begin
      errors++; $display("FAIL rstmid_followup got=%0d pairs res=%h err=%b exp=2 pairs res=4200 err=0",
        act_q.size(), got_res, got_err);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] len = 8'($urandom_range(1, 24));
      logic [15:0] r = 16'($urandom);
      ready_mode = $urandom_range(0, 2);
      run_cmd(len, 12'($urandom), 12'($urandom), -1, r);
      checks++;
      if (pairs_bad || addr_bad || !done_ok || stab_viol != 0) begin
        errors++; $display("FAIL rand%0d_stream got=%0d pairs %0d reads unstable=%0d exp=%0d", k,
          act_q.size(), addr_q.size(), stab_viol, len);
      end
      checks++;
      if (got_res !== r || got_err !== 1'b0 || !idle_ok || !cv_ok) begin
        errors++; $display("FAIL rand%0d_result got=%h err=%b exp=%h err=0", k, got_res, got_err, r);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_daddr = '0; cmd_waddr = '0;
    mac_conv_ready = 1'b0; mac_data_ready = 1'b0; mac_result = '0; res_ready = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      dmem[i] = 16'($urandom);
      wmem[i] = 16'($urandom);
    end
    test_reset();
    test_nine();
    test_backpressure();
    test_len_zero();
    test_wrap();
    test_early();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
